// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths
// and default sizing parameters.
package mem_resp_pkg;

    localparam int MEM_AW_DEF   = 8;
    localparam int RD_LAT_DEF   = 2;
    localparam int WB_DEPTH_DEF = 2;
    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 16;
    localparam int CNT_W        = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Wait-counter preload: a read spends RD_LAT-1 cycles in WAIT before RESP.
    function automatic logic [CNT_W-1:0] wait_preset(input int lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_write_buffer.sv
// Small in-order write buffer: slot 0 is always the oldest entry, pops shift
// the queue down, and a combinational lookup returns the youngest index match.
module write_buffer
    import mem_resp_pkg::*;
#(
    parameter int AW    = MEM_AW_DEF,
    parameter int DW    = DATA_W,
    parameter int DEPTH = WB_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_idx,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] head_idx,
    output logic [DW-1:0] head_data,
    input  logic [AW-1:0] lookup_idx,
    output logic          lookup_hit,
    output logic [DW-1:0] lookup_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] idx_r  [DEPTH];
    logic [DW-1:0] dat_r  [DEPTH];
    logic [AW-1:0] idx_nx [DEPTH];
    logic [DW-1:0] dat_nx [DEPTH];
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] wr_pos_s;
    logic          push_s;
    logic          pop_s;

    assign full      = (cnt_r == CW'(DEPTH));
    assign empty     = (cnt_r == {CW{1'b0}});
    assign pop_s     = pop && !empty;
    assign push_s    = push && (!full || pop_s);
    assign wr_pos_s  = cnt_r - CW'(pop_s);
    assign head_idx  = idx_r[0];
    assign head_data = dat_r[0];

    // Occupancy counter; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(push_s) - CW'(pop_s);
        end
    end

    // Next slot contents: shift on pop, then place the new entry behind the rest.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            idx_nx[i] = idx_r[i];
            dat_nx[i] = dat_r[i];
        end
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                idx_nx[i] = idx_r[i + 1];
                dat_nx[i] = dat_r[i + 1];
            end
        end else begin
            idx_nx[0] = idx_r[0];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (wr_pos_s == CW'(i))) begin
                idx_nx[i] = push_idx;
                dat_nx[i] = push_data;
            end else begin
                dat_nx[i] = dat_nx[i];
            end
        end
    end

    // Entry storage carries no reset; only the occupancy count qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            idx_r[i] <= idx_nx[i];
            dat_r[i] <= dat_nx[i];
        end
    end

    // Youngest-match lookup: later (younger) valid slots override older ones.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < cnt_r) && (idx_r[i] == lookup_idx)) begin
                lookup_hit  = 1'b1;
                lookup_data = dat_r[i];
            end else begin
                lookup_hit = lookup_hit;
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Core-facing data-memory responder: fixed-latency loads, buffered stores
// that drain one per cycle into a reset-less register array.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              stall,
    output logic              wb_empty
);

    logic [DATA_W-1:0] mem_r [2**MEM_AW];

    state_e             state_r;
    state_e             state_nx;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nx;
    logic [DATA_W-1:0]  hold_r;
    logic               rsp_valid_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               rsp_valid_nx;
    logic [DATA_W-1:0]  rsp_rdata_nx;

    logic [MEM_AW-1:0]  idx_s;
    logic               addr_unused_s;
    logic               rd_acc_s;
    logic               wr_acc_s;
    logic [DATA_W-1:0]  rd_val_s;

    logic               wb_full_s;
    logic               wb_empty_s;
    logic [MEM_AW-1:0]  wb_head_idx_s;
    logic [DATA_W-1:0]  wb_head_data_s;
    logic               wb_hit_s;
    logic [DATA_W-1:0]  wb_hit_data_s;

    // Upper address bits are deliberately ignored, so addresses alias.
    assign idx_s         = req_addr[MEM_AW-1:0];
    assign addr_unused_s = ^req_addr[ADDR_W-1:MEM_AW];

    assign req_ready = ((state_r == ST_IDLE) || (state_r == ST_RESP)) && !wb_full_s;
    assign stall     = req_valid && !req_ready;
    assign rd_acc_s  = req_valid && req_ready && !req_we;
    assign wr_acc_s  = req_valid && req_ready && req_we;
    assign rd_val_s  = wb_hit_s ? wb_hit_data_s : mem_r[idx_s];

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign wb_empty  = wb_empty_s;

    write_buffer #(
        .AW    (MEM_AW),
        .DW    (DATA_W),
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk         (clk),
        .rst         (rst),
        .push        (wr_acc_s),
        .push_idx    (idx_s),
        .push_data   (req_wdata),
        .pop         (!wb_empty_s),
        .full        (wb_full_s),
        .empty       (wb_empty_s),
        .head_idx    (wb_head_idx_s),
        .head_data   (wb_head_data_s),
        .lookup_idx  (idx_s),
        .lookup_hit  (wb_hit_s),
        .lookup_data (wb_hit_data_s)
    );

    // Array write port: the oldest buffered store lands here every cycle.
    always_ff @(posedge clk) begin
        if (!wb_empty_s) begin
            mem_r[wb_head_idx_s] <= wb_head_data_s;
        end
    end

    // State register plus registered response outputs and captured load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            hold_r      <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_nx;
            cnt_r       <= cnt_nx;
            rsp_valid_r <= rsp_valid_nx;
            rsp_rdata_r <= rsp_rdata_nx;
            if (rd_acc_s) begin
                hold_r <= rd_val_s;
            end
        end
    end

    // Next-state logic; stores never move the FSM on their own.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            ST_IDLE, ST_RESP: begin
                if (rd_acc_s) begin
                    if (RD_LAT == 1) begin
                        state_nx = ST_RESP;
                        cnt_nx   = {CNT_W{1'b0}};
                    end else begin
                        state_nx = ST_WAIT;
                        cnt_nx   = wait_preset(RD_LAT);
                    end
                end else begin
                    state_nx = ST_IDLE;
                    cnt_nx   = {CNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_nx = ST_RESP;
                    cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    cnt_nx = cnt_r - 3'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output logic: response data changes only on entry to RESP.
    always_comb begin
        rsp_valid_nx = (state_nx == ST_RESP);
        rsp_rdata_nx = rsp_rdata_r;
        if (rsp_valid_nx) begin
            rsp_rdata_nx = rd_acc_s ? rd_val_s : hold_r;
        end else begin
            rsp_rdata_nx = rsp_rdata_r;
        end
    end

endmodule
